// File: rtl/arb_n_rr_pkg.sv
//------------------------------------------------------------------------------
// Module : arb_n_rr_pkg
// Brief  : Shared widths and arbitration-mode constants for the N-channel merge.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package arb_n_rr_pkg;

    localparam int WORD_BITS      = 32;

    localparam bit ARB_MODE_FIXED = 1'b0;
    localparam bit ARB_MODE_RR    = 1'b1;

endpackage : arb_n_rr_pkg

`default_nettype wire

// File: rtl/arb_rr_pick.sv
//------------------------------------------------------------------------------
// Module : arb_rr_pick
// Brief  : Combinational rotate-and-priority-encode grant picker.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module arb_rr_pick
    import arb_n_rr_pkg::*;
#(
    parameter int N = 4,
    parameter int B = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [B-1:0] i_last,
    input  logic         i_mode,
    output logic         o_exists,
    output logic [B-1:0] o_idx
);

    int w_base;
    int w_k;

    always_comb begin
        o_exists = 1'b0;
        o_idx    = '0;
        w_base   = 0;
        w_k      = 0;
        if (i_mode == ARB_MODE_RR) begin
            w_base = (int'(i_last) == N - 1) ? 0 : int'(i_last) + 1;
        end
        // Scan from the far end so the nearest requester to w_base is written last.
        for (int i = N - 1; i >= 0; i--) begin
            w_k = w_base + i;
            if (w_k >= N) begin
                w_k = w_k - N;
            end
            if (i_req[w_k]) begin
                o_exists = 1'b1;
                o_idx    = B'(w_k);
            end
        end
    end

endmodule : arb_rr_pick

`default_nettype wire

// File: rtl/arb_n_rr.sv
//------------------------------------------------------------------------------
// Module : arb_n_rr
// Brief  : N-channel valid/ready merge with registered output, fixed or RR grant.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module arb_n_rr
    import arb_n_rr_pkg::*;
#(
    parameter int p_st_bits = WORD_BITS,
    parameter int p_ch      = 4,
    parameter int p_rr      = 1,
    parameter int p_ch_bits = $clog2(p_ch)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [p_ch*p_st_bits-1:0] iSnkData,
    input  logic [p_ch-1:0]           iSnkValid,
    output logic [p_ch-1:0]           oSnkReady,
    output logic [p_st_bits-1:0]      oSrc0Data,
    output logic                      oSrc0Valid,
    output logic [p_ch_bits-1:0]      oSrc0Chan,
    input  logic                      iSrc0Ready
);

    localparam bit c_MODE = (p_rr != 0) ? ARB_MODE_RR : ARB_MODE_FIXED;

    logic                 r_valid;
    logic [p_st_bits-1:0] r_data;
    logic [p_ch_bits-1:0] r_chan;
    logic [p_ch_bits-1:0] r_last;

    logic                 w_load;
    logic                 w_exists;
    logic                 w_take;
    logic [p_ch_bits-1:0] w_idx;
    logic [p_st_bits-1:0] w_sel_data;

    arb_rr_pick #(
        .N (p_ch),
        .B (p_ch_bits)
    ) u_pick (
        .i_req    (iSnkValid),
        .i_last   (r_last),
        .i_mode   (c_MODE),
        .o_exists (w_exists),
        .o_idx    (w_idx)
    );

    assign w_load     = ~r_valid | iSrc0Ready;
    // Reset gates the accept so no sink word is consumed during a reset cycle.
    assign w_take     = rst & w_load & w_exists;
    assign oSnkReady  = w_take ? (p_ch'(1) << w_idx) : '0;
    assign w_sel_data = iSnkData[int'(w_idx)*p_st_bits +: p_st_bits];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_chan  <= '0;
            r_last  <= p_ch_bits'(p_ch - 1);
        end else if (w_take) begin
            r_valid <= 1'b1;
            r_data  <= w_sel_data;
            r_chan  <= w_idx;
            if (c_MODE == ARB_MODE_RR) begin
                r_last <= w_idx;
            end
        end else if (iSrc0Ready) begin
            r_valid <= 1'b0;
        end
    end

    assign oSrc0Data  = r_data;
    assign oSrc0Valid = r_valid;
    assign oSrc0Chan  = r_chan;

endmodule : arb_n_rr

`default_nettype wire

// File: tb/tb_arb_n_rr.sv
//------------------------------------------------------------------------------
// Module : tb_arb_n_rr
// Brief  : Directed and scoreboarded checks of arb_n_rr in RR and fixed modes.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_arb_n_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [127:0] rr_data  = '0;
    logic [3:0]   rr_valid = '0;
    logic [3:0]   rr_ready;
    logic [31:0]  rr_odata;
    logic         rr_ovalid;
    logic [1:0]   rr_ochan;
    logic         rr_oready = 1'b0;

    logic [127:0] fx_data  = '0;
    logic [3:0]   fx_valid = '0;
    logic [3:0]   fx_ready;
    logic [31:0]  fx_odata;
    logic         fx_ovalid;
    logic [1:0]   fx_ochan;
    logic         fx_oready = 1'b0;

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    arb_n_rr #(.p_st_bits(32), .p_ch(4), .p_rr(1)) u_rr (
        .clk        (clk),
        .rst        (rst),
        .iSnkData   (rr_data),
        .iSnkValid  (rr_valid),
        .oSnkReady  (rr_ready),
        .oSrc0Data  (rr_odata),
        .oSrc0Valid (rr_ovalid),
        .oSrc0Chan  (rr_ochan),
        .iSrc0Ready (rr_oready)
    );

    arb_n_rr #(.p_st_bits(32), .p_ch(4), .p_rr(0)) u_fx (
        .clk        (clk),
        .rst        (rst),
        .iSnkData   (fx_data),
        .iSnkValid  (fx_valid),
        .oSnkReady  (fx_ready),
        .oSrc0Data  (fx_odata),
        .oSrc0Valid (fx_ovalid),
        .oSrc0Chan  (fx_ochan),
        .iSrc0Ready (fx_oready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        rr_valid  = 4'b1111;
        rr_oready = 1'b1;
        for (int k = 0; k < 4; k++) rr_data[k*32 +: 32] = 32'hA0 + k;
        for (int c = 0; c < 3; c++) begin
            step();
            vec++;
            if (rr_ovalid !== 1'b0 || rr_odata !== 32'h0 || rr_ready !== 4'b0000) begin
                miss++;
                $display("FAIL reset cyc%0d: valid=%b data=%h ready=%b, want 0/0/0000",
                         c, rr_ovalid, rr_odata, rr_ready);
            end
        end
        rst = 1'b1;
        #1;
        vec++;
        if (rr_ready !== 4'b0001) begin
            miss++;
            $display("FAIL reset_first_grant: ready=%b want 0001", rr_ready);
        end
    endtask

    task automatic test_rr_saturation();
        for (int i = 0; i < 5; i++) begin
            step();
            vec++;
            if (rr_ovalid !== 1'b1 || rr_odata !== 32'hA0 + (i % 4) || rr_ochan !== 2'(i % 4)) begin
                miss++;
                $display("FAIL rr_sat[%0d]: valid=%b data=%h chan=%0d, want 1/%h/%0d",
                         i, rr_ovalid, rr_odata, rr_ochan, 32'hA0 + (i % 4), i % 4);
            end
        end
        rr_valid = 4'b0000;
        step();
        vec++;
        if (rr_ovalid !== 1'b0 || rr_odata !== 32'hA0 || rr_ochan !== 2'd0) begin
            miss++;
            $display("FAIL rr_drain: valid=%b data=%h chan=%0d, want 0/a0/0",
                     rr_ovalid, rr_odata, rr_ochan);
        end
    endtask

    task automatic test_sparse_wrap();
        rr_valid = 4'b1000;
        rr_data[3*32 +: 32] = 32'h33;
        step();
        rr_valid = 4'b0100;
        rr_data[2*32 +: 32] = 32'h22;
        #1;
        vec++;
        if (rr_ready !== 4'b0100) begin
            miss++;
            $display("FAIL sparse_grant2: ready=%b want 0100", rr_ready);
        end
        step();
        vec++;
        if (rr_odata !== 32'h22 || rr_ochan !== 2'd2) begin
            miss++;
            $display("FAIL sparse_out2: data=%h chan=%0d want 22/2", rr_odata, rr_ochan);
        end
        rr_valid = 4'b0101;
        rr_data[0 +: 32]    = 32'h02;
        rr_data[2*32 +: 32] = 32'h222;
        #1;
        vec++;
        if (rr_ready !== 4'b0001) begin
            miss++;
            $display("FAIL sparse_wrap: ready=%b want 0001", rr_ready);
        end
        step();
        rr_valid = 4'b0100;
        vec++;
        if (rr_odata !== 32'h02 || rr_ochan !== 2'd0) begin
            miss++;
            $display("FAIL sparse_out0: data=%h chan=%0d want 02/0", rr_odata, rr_ochan);
        end
        step();
        rr_valid = 4'b0000;
        vec++;
        if (rr_odata !== 32'h222 || rr_ochan !== 2'd2) begin
            miss++;
            $display("FAIL sparse_out2b: data=%h chan=%0d want 222/2", rr_odata, rr_ochan);
        end
        step();
    endtask

    task automatic test_backpressure();
        rr_oready = 1'b0;
        rr_valid  = 4'b0010;
        rr_data[1*32 +: 32] = 32'h55;
        step();
        rr_valid = 4'b0100;
        rr_data[2*32 +: 32] = 32'h77;
        for (int c = 0; c < 5; c++) begin
            #1;
            vec++;
            if (rr_odata !== 32'h55 || rr_ovalid !== 1'b1 || rr_ready !== 4'b0000) begin
                miss++;
                $display("FAIL stall[%0d]: data=%h valid=%b ready=%b want 55/1/0000",
                         c, rr_odata, rr_ovalid, rr_ready);
            end
            step();
        end
        rr_oready = 1'b1;
        #1;
        vec++;
        if (rr_ready !== 4'b0100) begin
            miss++;
            $display("FAIL stall_release: ready=%b want 0100", rr_ready);
        end
        step();
        rr_valid = 4'b0000;
        vec++;
        if (rr_odata !== 32'h77 || rr_ochan !== 2'd2) begin
            miss++;
            $display("FAIL stall_out: data=%h chan=%0d want 77/2", rr_odata, rr_ochan);
        end
        step();
    endtask

    task automatic test_fixed();
        fx_oready = 1'b1;
        fx_valid  = 4'b1010;
        fx_data[1*32 +: 32] = 32'h11;
        fx_data[3*32 +: 32] = 32'h33;
        #1;
        vec++;
        if (fx_ready !== 4'b0010) begin
            miss++;
            $display("FAIL fixed_grant: ready=%b want 0010", fx_ready);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            vec++;
            if (fx_odata !== 32'h11 || fx_ochan !== 2'd1 || fx_ovalid !== 1'b1) begin
                miss++;
                $display("FAIL fixed_hi[%0d]: data=%h chan=%0d valid=%b want 11/1/1",
                         i, fx_odata, fx_ochan, fx_ovalid);
            end
        end
        fx_valid = 4'b1000;
        #1;
        vec++;
        if (fx_ready !== 4'b1000) begin
            miss++;
            $display("FAIL fixed_lo_grant: ready=%b want 1000", fx_ready);
        end
        step();
        fx_valid = 4'b0000;
        vec++;
        if (fx_odata !== 32'h33 || fx_ochan !== 2'd3) begin
            miss++;
            $display("FAIL fixed_lo: data=%h chan=%0d want 33/3", fx_odata, fx_ochan);
        end
        step();
        vec++;
        if (fx_ovalid !== 1'b0) begin
            miss++;
            $display("FAIL fixed_drain: valid=%b want 0", fx_ovalid);
        end
    endtask

    task automatic test_reset_mid_stall();
        rr_oready = 1'b0;
        rr_valid  = 4'b0001;
        rr_data[0 +: 32] = 32'hC0;
        step();
        vec++;
        if (rr_ovalid !== 1'b1 || rr_odata !== 32'hC0) begin
            miss++;
            $display("FAIL midrst_setup: valid=%b data=%h want 1/c0", rr_ovalid, rr_odata);
        end
        rr_valid = 4'b0011;
        rr_data[1*32 +: 32] = 32'hC1;
        rst       = 1'b0;
        rr_oready = 1'b1;
        #1;
        vec++;
        if (rr_ready !== 4'b0000) begin
            miss++;
            $display("FAIL midrst_ready: ready=%b want 0000", rr_ready);
        end
        step();
        vec++;
        if (rr_ovalid !== 1'b0 || rr_odata !== 32'h0) begin
            miss++;
            $display("FAIL midrst_flush: valid=%b data=%h want 0/0", rr_ovalid, rr_odata);
        end
        rst = 1'b1;
        #1;
        vec++;
        if (rr_ready !== 4'b0001) begin
            miss++;
            $display("FAIL midrst_ptr: ready=%b want 0001", rr_ready);
        end
        step();
        rr_valid = 4'b0010;
        vec++;
        if (rr_odata !== 32'hC0 || rr_ochan !== 2'd0) begin
            miss++;
            $display("FAIL midrst_out: data=%h chan=%0d want c0/0", rr_odata, rr_ochan);
        end
        step();
        rr_valid = 4'b0000;
        step();
        step();
    endtask

    task automatic test_random();
        int         gen  [4];
        int         acc_n[4];
        int         exp_n[4];
        logic [3:0] acc;
        logic       fire;
        logic [1:0] fch;
        logic [31:0] fdat;
        for (int k = 0; k < 4; k++) begin
            gen[k] = 0; acc_n[k] = 0; exp_n[k] = 0;
        end
        for (int cyc = 0; cyc < 1030; cyc++) begin
            if (cyc < 1000) begin
                for (int k = 0; k < 4; k++) begin
                    if (!rr_valid[k] && $urandom_range(0, 2) != 0) begin
                        rr_valid[k] = 1'b1;
                        rr_data[k*32 +: 32] = {8'(k), 24'(gen[k])};
                        gen[k]++;
                    end
                end
                rr_oready = ($urandom_range(0, 3) != 0);
            end else begin
                rr_oready = 1'b1;
            end
            #1;
            acc  = rr_valid & rr_ready;
            fire = rr_ovalid & rr_oready;
            fch  = rr_ochan;
            fdat = rr_odata;
            if ($countones(rr_ready) > 1) begin
                vec++;
                miss++;
                $display("FAIL rand_onehot cyc%0d: ready=%b want at most one bit", cyc, rr_ready);
            end
            step();
            if (fire) begin
                vec++;
                if (exp_n[fch] >= acc_n[fch] || fdat !== {8'(fch), 24'(exp_n[fch])}) begin
                    miss++;
                    $display("FAIL rand_out cyc%0d: chan=%0d data=%h want %h (accepted %0d)",
                             cyc, fch, fdat, {8'(fch), 24'(exp_n[fch])}, acc_n[fch]);
                end
                exp_n[fch]++;
            end
            for (int k = 0; k < 4; k++) begin
                if (acc[k]) begin
                    acc_n[k]++;
                    rr_valid[k] = 1'b0;
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            vec++;
            if (exp_n[k] !== acc_n[k] || acc_n[k] !== gen[k] || acc_n[k] == 0) begin
                miss++;
                $display("FAIL rand_count ch%0d: out=%0d acc=%0d gen=%0d want all equal, nonzero",
                         k, exp_n[k], acc_n[k], gen[k]);
            end
        end
        vec++;
        if (rr_ovalid !== 1'b0 || rr_valid !== 4'b0000) begin
            miss++;
            $display("FAIL rand_idle: ovalid=%b svalid=%b want 0/0000", rr_ovalid, rr_valid);
        end
    endtask

    initial begin
        test_reset();
        test_rr_saturation();
        test_sparse_wrap();
        test_backpressure();
        test_fixed();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule : tb_arb_n_rr

`default_nettype wire

// File: doc/arb_n_rr.md
Name: arb_n_rr

Overview:
- Parametrised N-channel arbiter that merges p_ch valid/data sink streams into one source stream.
- Next generation of the three-input fixed-priority merge. Adds:
  - ready/valid backpressure on both sides
  - a registered output stage
  - selectable fixed-priority or round-robin arbitration
  - a granted-channel index output
- Sits between CPU sub-units (e.g. writeback/bus requesters) and a single shared consumer.

Parameters:
- p_st_bits, `WORD_BITS (32): data width per channel.
- p_ch, 4: number of sink channels; legal range 2..16.
- p_rr, 1: 0 = fixed priority (lowest index wins); 1 = round-robin.
- p_ch_bits, $clog2(p_ch): width of the channel index (derived; not overridden).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-low.
- iSnkData  in  p_ch*p_st_bits  packed sink data; channel k occupies bits [k*p_st_bits +: p_st_bits].
- iSnkValid  in  p_ch  per-channel valid.
- oSnkReady  out  p_ch  per-channel accept; at most one bit high per cycle.
- oSrc0Data  out  p_st_bits  registered output data.
- oSrc0Valid  out  1  registered output valid.
- oSrc0Chan  out  p_ch_bits  index of the channel that supplied oSrc0Data.
- iSrc0Ready  in  1  downstream accept.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst==0 at a rising clk edge):
  - oSrc0Valid=0, oSrc0Data=0, oSrc0Chan=0.
  - Round-robin pointer last=p_ch-1, so channel 0 has top priority first.
  - oSnkReady is 0 while rst==0.
- Load enable: load = ~oSrc0Valid | iSrc0Ready. The output register may take a new word when it is empty or is being drained in the same cycle.
- Grant (combinational):
  - p_rr=0: g = lowest k with iSnkValid[k].
  - p_rr=1: g = first k with iSnkValid[k], searching (last+1) mod p_ch upward with wrap-around.
  - No valid sink means no grant.
- oSnkReady[g] = load & grant_exists. All other bits are 0.
- Accept: a sink transfer occurs when iSnkValid[g] & oSnkReady[g]. On the next edge:
  - oSrc0Data <= sink g data
  - oSrc0Chan <= g
  - oSrc0Valid <= 1
  - last <= g (round-robin only; fixed mode ignores last)
- Drain without refill: if iSrc0Ready & oSrc0Valid and no sink is granted, then oSrc0Valid <= 0. oSrc0Data and oSrc0Chan hold their old values.
- Stall: while oSrc0Valid & ~iSrc0Ready:
  - all oSnkReady = 0
  - oSrc0Data, oSrc0Chan, oSrc0Valid and last hold.
- Latency and throughput:
  - One cycle from sink accept to oSrc0Valid.
  - Sustained throughput is 1 word/cycle when iSrc0Ready is held high.
- Fairness (p_rr=1): with all p_ch sinks continuously valid, grants cycle 0,1,...,p_ch-1,0,... Each channel is served exactly once per p_ch accepts.
- Pointer stability: last changes only on an actual accept, never on idle or stall cycles.
- Sink rules:
  - A sink must hold data/valid stable until accepted.
  - The block never drops or duplicates a word.
- Combinational paths:
  - oSnkReady depends on iSnkValid, iSrc0Ready and register state.
  - There is no combinational path from iSnkData to any output.
- Reset mid-operation: a pending oSrc0Valid word is discarded, the pointer returns to p_ch-1, and no sink is accepted in the reset cycle.

Decomposition:
- Shared package/define file (`WORD_BITS already present). Add:
  - ARB_MODE_FIXED=0, ARB_MODE_RR=1 constants
  - a clog2 helper macro if it is not already provided
- One natural sub-module: arb_rr_pick.
  - Purely combinational rotate-and-priority-encode.
  - Inputs: request vector, last pointer, mode.
  - Outputs: grant_exists, grant index.
  - Reused by future bus arbiters.

Test Plan:
1. Reset/idle: hold rst=0 for 3 cycles with all iSnkValid=1111 -> oSrc0Valid=0, oSrc0Data=0, oSnkReady=0000. First grant after release is channel 0.
2. Round-robin saturation: p_ch=4, p_rr=1, all valid with data k=0xA0+k, iSrc0Ready=1 -> oSrc0Data sequence A0,A1,A2,A3,A0; oSrc0Chan 0,1,2,3,0; oSrc0Valid continuous.
3. Fixed priority: p_rr=0, sinks 1 and 3 valid (0x11, 0x33) -> 0x11 is output for every cycle sink 1 stays valid. 0x33 is accepted only after sink 1 deasserts.
4. Backpressure: output holds 0x55 and iSrc0Ready=0 for 5 cycles while sink 2 is valid with 0x77 -> oSrc0Data stays 0x55, oSnkReady=0000. On the cycle iSrc0Ready=1, oSnkReady=0100 and 0x77 appears the next cycle.
5. Sparse requests with wrap: last=3, only sink 2 valid -> grant 2, then last=2. Next, sinks 0 and 2 valid -> grant 0 (pointer wraps past 3).
6. Reset mid-stall: oSrc0Valid=1 stalled, then rst=0 for one cycle -> oSrc0Valid=0 next cycle and no sink accepted. Afterwards, a random 1000-cycle run is checked by a scoreboard for no loss, no duplication and per-channel ordering.
